// File: rtl/assist_pkg.sv
// Shared types and helpers for the motor-assist controller and the telemetry block.
//   assist_state_t : controller FSM state encoding, also exported on the state port
//   sat_clamp      : signed clamp of a value into [lo, hi]
package assist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSIST = 2'd1,
    BRAKE  = 2'd2
  } assist_state_t;

  // Working width for saturation; wide enough for every target expression we build.
  localparam int SAT_W = 32;

  function automatic logic signed [SAT_W-1:0] sat_clamp(
    input logic signed [SAT_W-1:0] val,
    input logic signed [SAT_W-1:0] lo,
    input logic signed [SAT_W-1:0] hi
  );
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction

endpackage

// File: rtl/assist_controller_cadence_monitor.sv
// Pedalling detector for the crank cadence sensor.
//   clk, reset_n : system clock, async active-low reset
//   cadence      : asynchronous crank pulse input
//   clear        : forget previously seen edges (controller leaving ASSIST / holding BRAKE)
//   pedalling    : high while edges keep arriving within CAD_TIMEOUT clocks
module cadence_monitor #(
  parameter int CAD_TIMEOUT = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic cadence,
  input  logic clear,
  output logic pedalling
);

  localparam int CW = $clog2(CAD_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(CAD_TIMEOUT);

  logic          cad_s1;
  logic          cad_s2;
  logic          cad_d;
  logic          seen;
  logic [CW-1:0] cnt;
  logic          cad_edge;

  assign cad_edge = cad_s2 & ~cad_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cad_s1 <= 1'b0;
      cad_s2 <= 1'b0;
      cad_d  <= 1'b0;
      cnt    <= '0;
      seen   <= 1'b0;
    end else begin
      cad_s1 <= cadence;
      cad_s2 <= cad_s1;
      cad_d  <= cad_s2;
      if (cad_edge)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
      // clear beats a coincident edge so that braking always wins
      if (clear)
        seen <= 1'b0;
      else if (cad_edge)
        seen <= 1'b1;
    end
  end

  assign pedalling = seen && (cnt < CNT_MAX);

endmodule

// File: rtl/assist_controller.sv
// Motor-assist controller: blends incline angle and heart-rate excess into a
// saturated, rate-limited PWM command, gated by pedalling and a brake cut-out.
//   clk, reset_n   : system clock, async active-low reset
//   enable         : assist enable, low forces IDLE
//   resolved_angle : signed incline angle
//   heart_rate     : measured heart rate (bpm)
//   heart_rate_cap : rider heart-rate cap (bpm)
//   cadence        : async crank pulse
//   brake          : async brake switch, 1 = braking
//   pwm_out        : signed motor command in [0, PWM_MAX]
//   pedalling      : cadence-alive flag
//   state          : FSM state
//
// state  | meaning
// IDLE   | no assist, pwm forced to 0, waiting for enable + fresh pedalling
// ASSIST | pwm tracks target: instant drop, slew-limited rise
// BRAKE  | brake held, pwm forced to 0, pedalling history discarded
module assist_controller
  import assist_pkg::*;
#(
  parameter int ANGLE_W     = 10,
  parameter int HR_W        = 8,
  parameter int PWM_W       = 10,
  parameter int PWM_MAX     = 511,
  parameter int HR_SHIFT    = 0,
  parameter int SLEW_STEP   = 4,
  parameter int SLEW_DIV    = 1024,
  parameter int CAD_TIMEOUT = 50_000_000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic signed [ANGLE_W-1:0] resolved_angle,
  input  logic        [HR_W-1:0]    heart_rate,
  input  logic        [HR_W-1:0]    heart_rate_cap,
  input  logic                      cadence,
  input  logic                      brake,
  output logic signed [PWM_W-1:0]   pwm_out,
  output logic                      pedalling,
  output assist_state_t             state
);

  localparam int TW = ANGLE_W + HR_W + HR_SHIFT + 2;
  localparam int SW = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;

  logic                    brake_s1;
  logic                    brake_s;
  logic                    ped_clear;
  logic signed [TW-1:0]    angle_x;
  logic signed [TW-1:0]    hr_x;
  logic signed [TW-1:0]    cap_x;
  logic signed [TW-1:0]    diff;
  logic signed [TW-1:0]    excess;
  logic signed [TW-1:0]    sum;
  logic signed [PWM_W-1:0] target;
  logic signed [PWM_W:0]   bumped;
  logic signed [PWM_W-1:0] slew_up;
  logic [SW-1:0]           slew_cnt;
  logic                    slew_tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      brake_s1 <= 1'b0;
      brake_s  <= 1'b0;
    end else begin
      brake_s1 <= brake;
      brake_s  <= brake_s1;
    end
  end

  // Pedalling history is dropped on any exit from ASSIST and for the whole of
  // BRAKE, so only an edge seen after release can re-arm assist.
  assign ped_clear = (state == BRAKE) ||
                     ((state == ASSIST) && (brake_s || !enable || !pedalling));

  cadence_monitor #(
    .CAD_TIMEOUT (CAD_TIMEOUT)
  ) u_cadence_monitor (
    .clk       (clk),
    .reset_n   (reset_n),
    .cadence   (cadence),
    .clear     (ped_clear),
    .pedalling (pedalling)
  );

  assign angle_x = TW'(resolved_angle);
  assign hr_x    = $signed(TW'(heart_rate));
  assign cap_x   = $signed(TW'(heart_rate_cap));
  assign diff    = hr_x - cap_x;
  assign excess  = (diff > 0) ? (diff <<< HR_SHIFT) : '0;
  assign sum     = angle_x + excess;
  assign target  = PWM_W'(sat_clamp(SAT_W'(sum), '0, SAT_W'(PWM_MAX)));

  // One extra bit so pwm_out + SLEW_STEP cannot wrap before the min().
  assign bumped    = (PWM_W+1)'(pwm_out) + (PWM_W+1)'(SLEW_STEP);
  assign slew_up   = (bumped > (PWM_W+1)'(target)) ? target : PWM_W'(bumped);
  assign slew_tick = (slew_cnt == SW'(SLEW_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pwm_out  <= '0;
      slew_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          pwm_out  <= '0;
          slew_cnt <= '0;
          if (enable && pedalling && !brake_s)
            state <= ASSIST;
        end
        ASSIST: begin
          if (brake_s)
            state <= BRAKE;
          else if (!enable || !pedalling)
            state <= IDLE;
          slew_cnt <= slew_tick ? '0 : slew_cnt + SW'(1);
          if (target < pwm_out)
            pwm_out <= target;
          else if (slew_tick)
            pwm_out <= slew_up;
        end
        BRAKE: begin
          pwm_out  <= '0;
          slew_cnt <= '0;
          if (!brake_s)
            state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          pwm_out  <= '0;
          slew_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_assist_controller.sv
module tb_assist_controller;
  import assist_pkg::*;

  localparam int ANGLE_W     = 10;
  localparam int HR_W        = 8;
  localparam int PWM_W       = 10;
  localparam int PWM_MAX     = 511;
  localparam int HR_SHIFT    = 0;
  localparam int SLEW_STEP   = 4;
  localparam int SLEW_DIV    = 4;
  localparam int CAD_TIMEOUT = 100;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      enable;
  logic signed [ANGLE_W-1:0] resolved_angle;
  logic        [HR_W-1:0]    heart_rate;
  logic        [HR_W-1:0]    heart_rate_cap;
  logic                      cadence;
  logic                      brake;
  logic signed [PWM_W-1:0]   pwm_out;
  logic                      pedalling;
  assist_state_t             state;

  int checks = 0;
  int errors = 0;
  int cad_cnt = 0;
  bit cad_run = 1'b0;
  bit ok;

  always #5 clk = ~clk;

  assist_controller #(
    .ANGLE_W     (ANGLE_W),
    .HR_W        (HR_W),
    .PWM_W       (PWM_W),
    .PWM_MAX     (PWM_MAX),
    .HR_SHIFT    (HR_SHIFT),
    .SLEW_STEP   (SLEW_STEP),
    .SLEW_DIV    (SLEW_DIV),
    .CAD_TIMEOUT (CAD_TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .resolved_angle (resolved_angle),
    .heart_rate     (heart_rate),
    .heart_rate_cap (heart_rate_cap),
    .cadence        (cadence),
    .brake          (brake),
    .pwm_out        (pwm_out),
    .pedalling      (pedalling),
    .state          (state)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input assist_state_t want, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state == want) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cad(input int val, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cad_cnt == val) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_pwm(input int val, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(pwm_out) == val) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Crank pulses: 2 clocks high every 40 clocks, changing 2 time units after a rising clock edge.
  initial begin
    cadence = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (cad_run) begin
        cadence = (cad_cnt < 2);
        cad_cnt = (cad_cnt == 39) ? 0 : cad_cnt + 1;
      end else begin
        cadence = 1'b0;
        cad_cnt = 0;
      end
    end
  end

  initial begin
    reset_n        = 1'b0;
    enable         = 1'b1;
    resolved_angle = 10'sd50;
    heart_rate     = 8'd100;
    heart_rate_cap = 8'd100;
    brake          = 1'b0;
    cad_run        = 1'b1;

    // Reset holds everything at rest even with inputs active
    step(10);
    check_val("rst_pwm", int'(pwm_out), 0);
    check_val("rst_state", int'(state), int'(IDLE));
    check_val("rst_ped", int'(pedalling), 0);

    // Ramp to a plain angle target
    resolved_angle = 10'sd20;
    reset_n = 1'b1;
    wait_state(ASSIST, 60, ok);
    check_val("ramp_enter", int'(ok), 1);
    check_val("ramp_ped", int'(pedalling), 1);
    check_val("ramp_pwm0", int'(pwm_out), 0);
    for (int k = 1; k <= 5; k++) begin
      step(4);
      check_val("ramp_step", int'(pwm_out), 4 * k);
    end
    step(8);
    check_val("ramp_hold", int'(pwm_out), 20);

    // Heart-rate excess pushes target past PWM_MAX: 500 + 30 clamps to 511
    resolved_angle = 10'sd500;
    heart_rate     = 8'd150;
    heart_rate_cap = 8'd120;
    step(40);
    check_val("hr_mid", int'(pwm_out), 60);
    step(460);
    check_val("hr_clamp", int'(pwm_out), 511);

    // Negative angle with no excess: instant drop to 0
    resolved_angle = -10'sd30;
    heart_rate     = 8'd120;
    step(1);
    check_val("drop_pwm", int'(pwm_out), 0);
    check_val("drop_state", int'(state), int'(ASSIST));

    resolved_angle = 10'sd20;
    step(30);
    check_val("reramp_pwm", int'(pwm_out), 20);

    // Brake cut-out
    brake = 1'b1;
    step(2);
    check_val("brk_sync", int'(state), int'(ASSIST));
    step(1);
    check_val("brk_state", int'(state), int'(BRAKE));
    check_val("brk_pwm_hold", int'(pwm_out), 20);
    check_val("brk_ped", int'(pedalling), 0);
    step(1);
    check_val("brk_pwm0", int'(pwm_out), 0);
    step(60);
    check_val("brk_stay", int'(state), int'(BRAKE));

    // Release well away from a pulse and stop the crank: must not re-arm
    wait_cad(10, 45, ok);
    check_val("rel_phase", int'(ok), 1);
    brake   = 1'b0;
    cad_run = 1'b0;
    step(2);
    check_val("rel_sync", int'(state), int'(BRAKE));
    step(1);
    check_val("rel_idle", int'(state), int'(IDLE));
    step(20);
    check_val("rel_wait", int'(state), int'(IDLE));
    check_val("rel_ped", int'(pedalling), 0);
    check_val("rel_pwm", int'(pwm_out), 0);

    cad_run = 1'b1;
    wait_state(ASSIST, 10, ok);
    check_val("rearm_enter", int'(ok), 1);
    check_val("rearm_pwm0", int'(pwm_out), 0);
    step(4);
    check_val("rearm_pwm4", int'(pwm_out), 4);

    // Cadence timeout: last edge registered 3 clocks after the pulse starts
    wait_cad(3, 45, ok);
    check_val("to_phase", int'(ok), 1);
    cad_run = 1'b0;
    step(100);
    check_val("to_before", int'(pedalling), 1);
    step(1);
    check_val("to_ped", int'(pedalling), 0);
    step(1);
    check_val("to_state", int'(state), int'(IDLE));
    check_val("to_pwm_hold", int'(pwm_out), 20);
    step(1);
    check_val("to_pwm", int'(pwm_out), 0);

    // Asynchronous reset mid-ramp
    cad_run = 1'b1;
    wait_state(ASSIST, 10, ok);
    check_val("ar_enter", int'(ok), 1);
    wait_pwm(12, 20, ok);
    check_val("ar_pwm12", int'(ok), 1);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("ar_pwm", int'(pwm_out), 0);
    check_val("ar_state", int'(state), int'(IDLE));
    check_val("ar_ped", int'(pedalling), 0);
    step(2);
    reset_n = 1'b1;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
